display_timing_gen: RTL and testbench

- Raster timing generator that produces the signed pixel coordinates consumed by the test-card pattern blocks (o_x/o_y feed their i_x/i_y directly).
- Also produces the horizontal/vertical sync, data-enable and frame/line strobes for the video output stage.
- Blanking is mapped to negative coordinates, so (0,0) is the first active pixel and patterns decode only 0..H_RES-1 / 0..V_RES-1.

---
 rtl/display_timing_gen.sv | 97 +++++++++
 tb/tb_display_timing_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// Raster timing generator: signed pixel coordinates with blanking mapped to
// negative values, plus sync, data-enable and line/frame strobes. Every
// output is registered from next-state decode so all of them describe the
// same pixel in the same cycle.
module display_timing_gen #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  output logic signed [15:0] o_x,
  output logic signed [15:0] o_y,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic               o_line,
  output logic               o_frame
);

  // Coordinate landmarks; blanking lives at negative coordinates.
  localparam logic signed [15:0] H_STA  = 16'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [15:0] HS_STA = 16'(-(H_SYNC + H_BP));
  localparam logic signed [15:0] HS_END = 16'(-H_BP);
  localparam logic signed [15:0] H_END  = 16'(H_RES - 1);
  localparam logic signed [15:0] V_STA  = 16'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [15:0] VS_STA = 16'(-(V_SYNC + V_BP));
  localparam logic signed [15:0] VS_END = 16'(-V_BP);
  localparam logic signed [15:0] V_END  = 16'(V_RES - 1);
  localparam logic H_ACT = H_POL[0];
  localparam logic V_ACT = V_POL[0];

  logic signed [15:0] x_reg, y_reg, x_next, y_next;
  logic hsync_reg, vsync_reg, de_reg, line_reg, frame_reg;
  logic hsync_next, vsync_next, de_next, line_next, frame_next;

  // Next pixel position and the decode of that position, so the registered
  // flags line up with the registered coordinates.
  always_comb begin
    x_next     = x_reg + 16'sd1;
    y_next     = y_reg;
    line_next  = 1'b0;
    frame_next = 1'b0;
    if (x_reg == H_END) begin
      x_next    = H_STA;
      line_next = 1'b1;
      if (y_reg == V_END) begin
        y_next     = V_STA;
        frame_next = 1'b1;
      end else begin
        y_next = y_reg + 16'sd1;
      end
    end
    hsync_next = ((x_next >= HS_STA) && (x_next < HS_END)) ? H_ACT : ~H_ACT;
    // y only changes on a line wrap, so vsync edges are line-aligned.
    vsync_next = ((y_next >= VS_STA) && (y_next < VS_END)) ? V_ACT : ~V_ACT;
    de_next    = (x_next >= 16'sd0) && (y_next >= 16'sd0);
  end

  // Output registers; everything holds (strobes included) while i_en is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_reg     <= H_STA;
      y_reg     <= V_STA;
      hsync_reg <= ~H_ACT;
      vsync_reg <= ~V_ACT;
      de_reg    <= 1'b0;
      line_reg  <= 1'b0;
      frame_reg <= 1'b0;
    end else if (i_en) begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      hsync_reg <= hsync_next;
      vsync_reg <= vsync_next;
      de_reg    <= de_next;
      line_reg  <= line_next;
      frame_reg <= frame_next;
    end
  end

  assign o_x     = x_reg;
  assign o_y     = y_reg;
  assign o_hsync = hsync_reg;
  assign o_vsync = vsync_reg;
  assign o_de    = de_reg;
  assign o_line  = line_reg;
  assign o_frame = frame_reg;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: a default 640x480 instance and a small
// 32x16 instance with active-high syncs share clock, enable and reset.
// The reference model tracks a linear pixel index per frame and derives
// coordinates and flags from it arithmetically.
module tb_display_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic signed [15:0] a_x, a_y, b_x, b_y;
  logic a_hs, a_vs, a_de, a_ln, a_fr;
  logic b_hs, b_vs, b_de, b_ln, b_fr;

  always #5 clk = ~clk;

  display_timing_gen dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_x(a_x), .o_y(a_y), .o_hsync(a_hs), .o_vsync(a_vs),
    .o_de(a_de), .o_line(a_ln), .o_frame(a_fr)
  );

  display_timing_gen #(
    .H_RES(32), .V_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_x(b_x), .o_y(b_y), .o_hsync(b_hs), .o_vsync(b_vs),
    .o_de(b_de), .o_line(b_ln), .o_frame(b_fr)
  );

  int n_total = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state: position inside the frame and whether any advance happened
  // since reset (strobes need one).
  int pos_a = 0, pos_b = 0;
  bit adv = 1'b0;
  int frames_b = 0;
  localparam int TOT_A = 800 * 525;
  localparam int TOT_B = 40 * 19;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_a = 0;
      pos_b = 0;
      adv = 1'b0;
    end else if (en) begin
      pos_a = (pos_a + 1) % TOT_A;
      pos_b = (pos_b + 1) % TOT_B;
      adv = 1'b1;
      if (pos_b == 0) frames_b++;
    end
  end

  // Expected outputs for a pixel index under a given timing.
  function automatic void model(input int pos, input int res_h,
                                input int fp_h, input int sy_h, input int bp_h,
                                input int fp_v, input int sy_v, input int bp_v,
                                input int pol_h, input int pol_v, input bit advd,
                                output int x, output int y, output int hs,
                                output int vs, output int de, output int ln,
                                output int fr);
    int ht, hsta, vsta;
    ht   = res_h + fp_h + sy_h + bp_h;
    hsta = -(fp_h + sy_h + bp_h);
    vsta = -(fp_v + sy_v + bp_v);
    x  = hsta + pos % ht;
    y  = vsta + pos / ht;
    hs = (x >= hsta + fp_h && x < hsta + fp_h + sy_h) ? pol_h : 1 - pol_h;
    vs = (y >= vsta + fp_v && y < vsta + fp_v + sy_v) ? pol_v : 1 - pol_v;
    de = (x >= 0 && y >= 0) ? 1 : 0;
    ln = (advd && (pos % ht == 0)) ? 1 : 0;
    fr = (advd && pos == 0) ? 1 : 0;
  endfunction

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    int x, y, hs, vs, de, ln, fr;
    if (chk_on) begin
      model(pos_a, 640, 16, 96, 48, 10, 2, 33, 0, 0, adv, x, y, hs, vs, de, ln, fr);
      check("a_x", int'(a_x), x);
      check("a_y", int'(a_y), y);
      check("a_hsync", int'(a_hs), hs);
      check("a_vsync", int'(a_vs), vs);
      check("a_de", int'(a_de), de);
      check("a_line", int'(a_ln), ln);
      check("a_frame", int'(a_fr), fr);
      model(pos_b, 32, 2, 4, 2, 1, 1, 1, 1, 1, adv, x, y, hs, vs, de, ln, fr);
      check("b_x", int'(b_x), x);
      check("b_y", int'(b_y), y);
      check("b_hsync", int'(b_hs), hs);
      check("b_vsync", int'(b_vs), vs);
      check("b_de", int'(b_de), de);
      check("b_line", int'(b_ln), ln);
      check("b_frame", int'(b_fr), fr);
    end
  end

  task automatic run_phase(input string name, input int cycles, input int mode);
    int f0;
    f0 = frames_b;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      case (mode)
        0: en = 1'b1;
        1: en = ((i % 4) == 0) || ((i % 4) == 3);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
    end
    $display("phase %s: cycles=%0d small_frames=%0d a=(%0d,%0d)",
             name, cycles, frames_b - f0, a_x, a_y);
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ax", int'(a_x), -160);
    check("rst_ay", int'(a_y), -45);
    check("rst_ahs", int'(a_hs), 1);
    check("rst_avs", int'(a_vs), 1);
    check("rst_ade", int'(a_de), 0);
    check("rst_bx", int'(b_x), -8);
    check("rst_by", int'(b_y), -3);
    check("rst_bhs", int'(b_hs), 0);
    check("rst_bvs", int'(b_vs), 0);
    check("rst_bln", int'(b_ln), 0);
    check("rst_bfr", int'(b_fr), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("phase %s: async reset applied and released", name);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("init_ax", int'(a_x), -160);
    check("init_ay", int'(a_y), -45);
    check("init_ade", int'(a_de), 0);
    check("init_aln", int'(a_ln), 0);
    check("init_afr", int'(a_fr), 0);
    chk_on = 1'b1;
    rst_n = 1'b1;
    run_phase("steady_en", 12000, 0);
    run_phase("en_1001", 6000, 1);
    run_phase("random_en", 6000, 2);
    async_reset("mid_frame");
    run_phase("after_reset", 5000, 2);
    run_phase("steady_en2", 3000, 0);
    async_reset("second");
    run_phase("final", 2000, 1);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
